// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing helpers, receiver state encoding and
// frame geometry. Used by both uart_recv and uart_send.
package uart_pkg;

  // Data bits per frame (8N1).
  localparam int DATA_BITS = 8;

  // Receiver state encoding; the numeric values are visible on the debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // System clocks per serial bit.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // System clocks from the start of a bit to its centre.
  function automatic int calc_half_cnt(input int bps_cnt);
    return bps_cnt / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous serial input plus a falling-edge
// detector used to spot the leading edge of a start bit.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic rxd_s,
  output logic start_edge
);

  logic rxd_d0_q;
  logic rxd_d1_q;
  logic rxd_d2_q;

  // Shift the line through three flops; reset to the idle-high level so that
  // leaving reset never looks like a falling edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_d0_q <= 1'b1;
      rxd_d1_q <= 1'b1;
      rxd_d2_q <= 1'b1;
    end else begin
      rxd_d0_q <= uart_rxd;
      rxd_d1_q <= rxd_d0_q;
      rxd_d2_q <= rxd_d1_q;
    end
  end

  // rxd_d1 is the sampled line; a 1 -> 0 step between d2 and d1 is a start edge.
  assign rxd_s      = rxd_d1_q;
  assign start_edge = rxd_d2_q & ~rxd_d1_q;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver. Waits for a falling edge, confirms the start bit at its
// centre, samples eight data bits LSB first at their centres, then checks the
// stop bit. A good frame updates uart_dout with a one-cycle uart_done; a low
// stop bit gives a one-cycle uart_frame_err and leaves uart_dout alone.
// The FSM returns to IDLE at mid-stop-bit so back-to-back frames are caught.
//
// Handshake: uart_done / uart_frame_err are single-cycle strobes with no
// backpressure; the consumer must capture uart_dout in the uart_done cycle or
// any later cycle before the next uart_done.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 65_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_dout,
  output logic       uart_done,
  output logic       uart_frame_err,
  output logic       uart_rx_busy,
  output logic [1:0] uart_rx_state
);

  localparam int BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int HALF_CNT = calc_half_cnt(BPS_CNT);
  localparam int CNT_W    = $clog2(BPS_CNT);

  logic rxd_s;
  logic start_edge;

  rx_state_e      state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     dout_q, dout_d;
  logic           done_q, done_d;
  logic           ferr_q, ferr_d;
  logic           bit_mid;
  logic           bit_end;

  uart_rx_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (uart_rxd),
    .rxd_s      (rxd_s),
    .start_edge (start_edge)
  );

  assign bit_mid = (clk_cnt_q == CNT_W'(HALF_CNT - 1));
  assign bit_end = (clk_cnt_q == CNT_W'(BPS_CNT - 1));

  // Register all receiver state; reset aborts any frame in progress at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state, bit timing, data capture and strobe generation.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;

    // Bit-period counter: parked at 0 when idle, wraps every BPS_CNT clocks.
    if (state_q == IDLE) begin
      clk_cnt_d = '0;
    end else if (bit_end) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
        end
      end
      START: begin
        // A line already back high at mid-start-bit was a glitch.
        if (bit_mid && rxd_s) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_mid) begin
          shift_d[bit_cnt_q] = rxd_s;
        end
        if (bit_end) begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_mid) begin
          state_d = IDLE;
          if (rxd_s) begin
            dout_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state entry starts a fresh bit period.
    if (state_d != state_q) begin
      clk_cnt_d = '0;
    end
  end

  assign uart_dout      = dout_q;
  assign uart_done      = done_q;
  assign uart_frame_err = ferr_q;
  assign uart_rx_busy   = (state_q != IDLE);
  assign uart_rx_state  = state_q;

endmodule

// File: tb/tb_uart_recv.sv
// Directed testbench for uart_recv at default parameters (564 clocks/bit).
// Serial frames are generated by a behavioural sender task with ideal timing.
module tb_uart_recv;

  localparam int BPS  = 564;
  localparam int HALF = 282;
  localparam int STOP_LAT = 5360;  // edge k (first edge seeing rxd low) to stop-sample edge

  logic       sys_clk;
  logic       sys_rst_n;
  logic       uart_rxd;
  logic [7:0] uart_dout;
  logic       uart_done;
  logic       uart_frame_err;
  logic       uart_rx_busy;
  logic [1:0] uart_rx_state;

  int pass_cnt;
  int total_cnt;
  int cyc;

  // Observations collected by the monitor.
  logic [7:0] got_q[$];
  int         done_cyc_q[$];
  int         ferr_cyc_q[$];
  int         busy_cnt;
  int         both_cnt;
  logic [7:0] exp_q[$];

  uart_recv dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .uart_rxd       (uart_rxd),
    .uart_dout      (uart_dout),
    .uart_done      (uart_done),
    .uart_frame_err (uart_frame_err),
    .uart_rx_busy   (uart_rx_busy),
    .uart_rx_state  (uart_rx_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: record strobes on the falling edge, after outputs have settled.
  always @(negedge sys_clk) begin
    if (uart_done) begin
      got_q.push_back(uart_dout);
      done_cyc_q.push_back(cyc);
    end
    if (uart_frame_err) ferr_cyc_q.push_back(cyc);
    if (uart_done && uart_frame_err) both_cnt++;
    if (uart_rx_busy) busy_cnt++;
  end

  // Watchdog against any unexpected stall.
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget (cyc=%0d, limit 95000)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    got_q.delete();
    done_cyc_q.delete();
    ferr_cyc_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    both_cnt = 0;
  endtask

  // Drive one 8N1 frame; called just after a falling clock edge.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rxd = bits[b];
      repeat (BPS) @(negedge sys_clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    idle_cycles(5);
    total_cnt++; if (uart_dout !== 8'h00) $display("FAIL reset_dout: got %h exp 00", uart_dout); else pass_cnt++;
    total_cnt++; if (uart_done !== 1'b0) $display("FAIL reset_done: got %b exp 0", uart_done); else pass_cnt++;
    total_cnt++; if (uart_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b exp 0", uart_frame_err); else pass_cnt++;
    total_cnt++; if (uart_rx_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", uart_rx_busy); else pass_cnt++;
    total_cnt++; if (uart_rx_state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", uart_rx_state); else pass_cnt++;
    sys_rst_n = 1'b1;
    clear_obs();
    idle_cycles(10000);
    total_cnt++; if (busy_cnt !== 0) $display("FAIL idle_busy: got %0d busy cycles exp 0", busy_cnt); else pass_cnt++;
    total_cnt++; if (got_q.size() !== 0) $display("FAIL idle_done: got %0d pulses exp 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (ferr_cyc_q.size() !== 0) $display("FAIL idle_ferr: got %0d pulses exp 0", ferr_cyc_q.size()); else pass_cnt++;
  endtask

  task automatic test_frame_a5();
    int k;
    clear_obs();
    k = cyc + 1;
    send_frame(8'hA5, 1'b1);
    idle_cycles(50);
    total_cnt++; if (got_q.size() !== 1) $display("FAIL a5_count: got %0d pulses exp 1", got_q.size()); else pass_cnt++;
    if (got_q.size() > 0) begin
      total_cnt++; if (got_q[0] !== 8'hA5) $display("FAIL a5_data: got %h exp a5", got_q[0]); else pass_cnt++;
      total_cnt++; if (done_cyc_q[0] !== k + STOP_LAT) $display("FAIL a5_latency: got cyc %0d exp %0d", done_cyc_q[0], k + STOP_LAT); else pass_cnt++;
    end
    total_cnt++; if (ferr_cyc_q.size() !== 0) $display("FAIL a5_ferr: got %0d pulses exp 0", ferr_cyc_q.size()); else pass_cnt++;
    total_cnt++; if (uart_rx_busy !== 1'b0) $display("FAIL a5_busy_after: got %b exp 0", uart_rx_busy); else pass_cnt++;
    total_cnt++; if (uart_dout !== 8'hA5) $display("FAIL a5_dout_hold: got %h exp a5", uart_dout); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int k;
    clear_obs();
    k = cyc + 1;
    uart_rxd = 1'b0;
    for (int j = 0; j < 400; j++) begin
      @(negedge sys_clk);
      if (cyc == k + 99) uart_rxd = 1'b1;
      if (cyc == k + 1) begin
        total_cnt++; if (uart_rx_busy !== 1'b0) $display("FAIL glitch_busy_pre: got %b exp 0", uart_rx_busy); else pass_cnt++;
      end
      if (cyc == k + 2) begin
        total_cnt++; if (uart_rx_busy !== 1'b1) $display("FAIL glitch_busy_start: got %b exp 1", uart_rx_busy); else pass_cnt++;
      end
      if (cyc == k + 1 + HALF) begin
        total_cnt++; if (uart_rx_busy !== 1'b1) $display("FAIL glitch_busy_mid: got %b exp 1", uart_rx_busy); else pass_cnt++;
      end
      if (cyc == k + 2 + HALF) begin
        total_cnt++; if (uart_rx_busy !== 1'b0) $display("FAIL glitch_busy_drop: got %b exp 0", uart_rx_busy); else pass_cnt++;
      end
    end
    total_cnt++; if (got_q.size() !== 0) $display("FAIL glitch_done: got %0d pulses exp 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (ferr_cyc_q.size() !== 0) $display("FAIL glitch_ferr: got %0d pulses exp 0", ferr_cyc_q.size()); else pass_cnt++;
    total_cnt++; if (uart_dout !== 8'hA5) $display("FAIL glitch_dout: got %h exp a5", uart_dout); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int k;
    clear_obs();
    k = cyc + 1;
    send_frame(8'h3C, 1'b0);
    idle_cycles(200);
    total_cnt++; if (ferr_cyc_q.size() !== 1) $display("FAIL ferr_count: got %0d pulses exp 1", ferr_cyc_q.size()); else pass_cnt++;
    if (ferr_cyc_q.size() > 0) begin
      total_cnt++; if (ferr_cyc_q[0] !== k + STOP_LAT) $display("FAIL ferr_latency: got cyc %0d exp %0d", ferr_cyc_q[0], k + STOP_LAT); else pass_cnt++;
    end
    total_cnt++; if (got_q.size() !== 0) $display("FAIL ferr_done: got %0d pulses exp 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (uart_dout !== 8'hA5) $display("FAIL ferr_dout: got %h exp a5", uart_dout); else pass_cnt++;
    total_cnt++; if (uart_rx_busy !== 1'b0) $display("FAIL ferr_busy_after: got %b exp 0", uart_rx_busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    bytes = '{8'h00, 8'hFF, 8'h55, 8'h81};
    clear_obs();
    for (int i = 0; i < 4; i++) exp_q.push_back(bytes[i]);
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
    idle_cycles(200);
    total_cnt++; if (got_q.size() !== 4) $display("FAIL b2b_count: got %0d pulses exp 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      if (i > 0 && i < done_cyc_q.size()) begin
        total_cnt++;
        if (done_cyc_q[i] - done_cyc_q[i-1] !== 10 * BPS)
          $display("FAIL b2b_spacing[%0d]: got %0d exp %0d", i, done_cyc_q[i] - done_cyc_q[i-1], 10 * BPS);
        else pass_cnt++;
      end
    end
    total_cnt++; if (ferr_cyc_q.size() !== 0) $display("FAIL b2b_ferr: got %0d pulses exp 0", ferr_cyc_q.size()); else pass_cnt++;
    total_cnt++; if (both_cnt !== 0) $display("FAIL b2b_both: got %0d overlapping cycles exp 0", both_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'h81, 1'b0};
    clear_obs();
    // Start bit and data bits 0..3, then partway into data bit 4.
    for (int b = 0; b < 5; b++) begin
      uart_rxd = bits[b];
      repeat (BPS) @(negedge sys_clk);
    end
    uart_rxd = bits[5];
    repeat (300) @(negedge sys_clk);
    total_cnt++; if (uart_rx_state !== 2'd2) $display("FAIL midrst_in_data: got state %0d exp 2", uart_rx_state); else pass_cnt++;
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    #1;
    total_cnt++; if (uart_rx_busy !== 1'b0) $display("FAIL midrst_busy: got %b exp 0", uart_rx_busy); else pass_cnt++;
    total_cnt++; if (uart_dout !== 8'h00) $display("FAIL midrst_dout: got %h exp 00", uart_dout); else pass_cnt++;
    total_cnt++; if (uart_rx_state !== 2'd0) $display("FAIL midrst_state: got %0d exp 0", uart_rx_state); else pass_cnt++;
    idle_cycles(10);
    sys_rst_n = 1'b1;
    idle_cycles(10);
    send_frame(8'h81, 1'b1);
    idle_cycles(50);
    total_cnt++; if (got_q.size() !== 1) $display("FAIL midrst_count: got %0d pulses exp 1", got_q.size()); else pass_cnt++;
    if (got_q.size() > 0) begin
      total_cnt++; if (got_q[0] !== 8'h81) $display("FAIL midrst_data: got %h exp 81", got_q[0]); else pass_cnt++;
    end
    total_cnt++; if (uart_dout !== 8'h81) $display("FAIL midrst_dout_after: got %h exp 81", uart_dout); else pass_cnt++;
    total_cnt++; if (ferr_cyc_q.size() !== 0) $display("FAIL midrst_ferr: got %0d pulses exp 0", ferr_cyc_q.size()); else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
